aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
- Sequential, multi-length AES inverse key-schedule generator for the AES_Decryption datapath.
- Loaded with the final Nk words of an expanded key (AES-128/192/256, selected at runtime).
- Walks the key schedule backwards one 32-bit word per cycle using a single 4-byte S-box.
- Emits round keys Nr down to 0 over a valid/ready handshake, feeding the inverse-cipher round pipeline in decryption order.

Parameters:
- MAX_KEY_BITS, 256, largest supported key length (128/192/256). Sets the kin width. key_len values above it are rejected.
- ROUND_W, 4, width of the rk_round output.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  load request; sampled only in IDLE
- key_len  in  2  00=AES-128 (Nk4,Nr10), 01=AES-192 (Nk6,Nr12), 10=AES-256 (Nk8,Nr14), 11 reserved
- kin  in  MAX_KEY_BITS  last Nk words w[4(Nr+1)-Nk .. 4Nr+3], left-justified, bit 0 = MSB of the lowest word; unused low-order bits ignored
- busy  out  1  high from accepted start until final handshake
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts rk_out
- rk_out  out  128  round key, bit 0 = MSB of word 4r
- rk_round  out  ROUND_W  round index r of rk_out
- done  out  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, window, counters and pending Rcon cleared. Reset mid-operation aborts the sequence with no done pulse.
- Window register holds Nk words w[j..j+Nk-1]. Round counter r.
- FSM states: IDLE, EMIT, STEP.
- IDLE:
  - start with valid key_len: load the window with j=4(Nr+1)-Nk, set r=Nr, busy=1.
  - Next state is EMIT if 4r>=j, otherwise STEP.
  - start with reserved key_len, or key length > MAX_KEY_BITS: start is ignored.
- STEP: one word per cycle.
  - Index i=j-1+Nk. Compute w[i-Nk] = w[i] ^ T(w[i-1]).
  - T = SubWord(RotWord(x)) ^ Rcon[i/Nk] when i mod Nk==0.
  - T = SubWord(x) when Nk==8 and i mod Nk==4.
  - Otherwise T is the identity.
  - Shift the window down (the new word becomes the lowest) and decrement j.
  - Go to EMIT once 4r>=j.
- EMIT:
  - rk_valid=1. rk_out = window words at offset 4r-j .. 4r-j+3. rk_round=r.
  - rk_out and rk_round are held stable while rk_valid && !rk_ready. No STEP occurs while waiting.
  - On handshake with r==0: go to IDLE, busy=0, done=1 for one cycle.
  - On handshake with r>0: decrement r, then go to EMIT if 4(r-1)>=j, else STEP.
  - rk_valid drops for at least the STEP cycles in between.
- Timing:
  - First rk_valid appears 1 cycle after the accepted start.
  - At most 4 STEP cycles occur between consecutive round keys.
  - Total with rk_ready tied high: AES-128 is 11 outputs plus 40 steps.
- start while busy is ignored. rk_ready while rk_valid=0 is ignored.
- Rcon is derived from the i/Nk counter via a package table; no division hardware.
- The key schedule uses the forward S-box.

Optional Feature:
- Macro AES_INV_KS_ERR_EN.
- When defined: adds output err (1 bit, reset 0). err pulses one cycle on a rejected start (reserved or over-size key_len) or on a start while busy.
- When undefined: err port is absent and such starts are silently ignored.

Decomposition:
- Package aes_ks_pkg holds:
  - key_len encoding constants
  - Nk/Nr lookup functions
  - 10-entry Rcon table
  - the 32-bit word typedef
- One natural sub-module: aes_sbox (forward, 8-bit, combinational), instantiated 4 times for SubWord.
- The FSM, window and counters live in the top module.

Test Plan:
- AES-128, kin = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1:
  - rk_round 10 carries d014f9a8..., rounds descend 10..0.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c, then done pulse.
- AES-192 and AES-256:
  - Load the last Nk words of the FIPS-197 A.2/A.3 expansions.
  - Every rk_out matches the golden forward-expansion model.
  - Round 0 equals the original key (8e73b0f7... / 603deb10...).
- Backpressure: toggle rk_ready randomly.
  - rk_out and rk_round stay stable while stalled.
  - No round is skipped or duplicated.
- Reset asserted mid-sequence (AES-256 at r=7):
  - All outputs go to 0 immediately and no done pulse is produced.
  - A subsequent start runs the full, correct sequence.
- start pulsed while busy, and start with key_len=11:
  - Both are ignored; the sequence is unchanged.
  - With AES_INV_KS_ERR_EN, err pulses once for each.

Source files
------------

// File: rtl/aes_ks_pkg.sv
// Shared types, key-length encodings, Nk/Nr/Rcon lookups and GF(2^8) helper
// for the AES inverse key-schedule generator.
package aes_ks_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] KL_128  = 2'b00;
    localparam logic [1:0] KL_192  = 2'b01;
    localparam logic [1:0] KL_256  = 2'b10;
    localparam logic [1:0] KL_RSVD = 2'b11;

    // Rcon[1..10] stored at index 0..9
    localparam logic [7:0] RCON_TAB [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // Lowest word index of the loaded window: 4(Nr+1)-Nk
    function automatic logic [5:0] j0_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd46;
            KL_256:  return 6'd52;
            default: return 6'd40;
        endcase
    endfunction

    // (4(Nr+1)-1) / Nk; the matching remainder is 3 for every key length
    function automatic logic [3:0] q0_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd8;
            KL_256:  return 4'd7;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] q);
        if (q >= 4'd1 && q <= 4'd10)
            return RCON_TAB[q - 4'd1];
        return 8'h00;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k])
                p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Load/round-key handshake bundle for aes_inv_key_sched.
// Carries the err pulse only when AES_INV_KS_ERR_EN is defined.
interface aes_inv_key_sched_if #(
    parameter int MAX_KEY_BITS = 256,
    parameter int ROUND_W      = 4
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] kin;
    logic                    busy;
    logic                    rk_valid;
    logic                    rk_ready;
    logic [127:0]            rk_out;
    logic [ROUND_W-1:0]      rk_round;
    logic                    done;
`ifdef AES_INV_KS_ERR_EN
    logic                    err;
`endif

    modport master (
        output start, key_len, kin, rk_ready,
`ifdef AES_INV_KS_ERR_EN
        input  err,
`endif
        input  busy, rk_valid, rk_out, rk_round, done
    );

    modport slave (
        input  start, key_len, kin, rk_ready,
`ifdef AES_INV_KS_ERR_EN
        output err,
`endif
        output busy, rk_valid, rk_out, rk_round, done
    );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_ks_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // x^254 == x^-1 for x != 0, and maps 0 to 0
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES key-schedule walker: emits round keys Nr..0, one recovered word per STEP.
// Define AES_INV_KS_ERR_EN to add the err pulse for rejected/busy starts.
module aes_inv_key_sched
    import aes_ks_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int ROUND_W      = 4
) (
    input logic                 clk,
    input logic                 rst,
    aes_inv_key_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EMIT, STEP} state_t;

    state_t             state_reg;
    word_t [7:0]        win_reg;
    logic [5:0]         j_reg;
    logic [3:0]         r_reg;
    logic [2:0]         phase_reg;
    logic [3:0]         quot_reg;
    logic [1:0]         kl_reg;
    logic               busy_reg;
    logic               rk_valid_reg;
    logic [127:0]       rk_out_reg;
    logic [ROUND_W-1:0] rk_round_reg;
    logic               done_reg;
`ifdef AES_INV_KS_ERR_EN
    logic               err_reg;
`endif

    word_t [7:0] kin_w;
    word_t       prev_word, top_word, sbox_in, sub_word, t_word, new_word;
    word_t [7:0] win_shift;
    logic        key_ok;
    logic [3:0]  r_dec;
    logic [5:0]  j_dec;
    logic [6:0]  diff_emit, diff_step;
    logic        ge_emit, ge_step;

    // kin is left-justified: word k sits just below word k-1 from the top
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_kin
            if ((gi + 1) * 32 <= MAX_KEY_BITS) begin : g_word
                assign kin_w[gi] = bus.kin[MAX_KEY_BITS-1-32*gi -: 32];
            end else begin : g_none
                assign kin_w[gi] = '0;
            end
        end
    endgenerate

    assign key_ok = (bus.key_len != KL_RSVD) &&
                    (32 * int'(nk_of(bus.key_len)) <= MAX_KEY_BITS);

    always_comb begin
        case (kl_reg)
            KL_192: begin
                prev_word = win_reg[4];
                top_word  = win_reg[5];
            end
            KL_256: begin
                prev_word = win_reg[6];
                top_word  = win_reg[7];
            end
            default: begin
                prev_word = win_reg[2];
                top_word  = win_reg[3];
            end
        endcase
    end

    assign sbox_in = (phase_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (sbox_in[8*gi +: 8]),
                .s (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        if (phase_reg == 3'd0)
            t_word = sub_word ^ {rcon_of(quot_reg), 24'h000000};
        else if (kl_reg == KL_256 && phase_reg == 3'd4)
            t_word = sub_word;
        else
            t_word = prev_word;
    end

    // w[i-Nk] = w[i] ^ T(w[i-1]); the recovered word enters at the bottom
    assign new_word  = top_word ^ t_word;
    assign win_shift = {win_reg[6:0], new_word};

    // Inside a valid window 4r-j is 0..Nk-4, so its upper bits are all zero
    assign r_dec     = r_reg - 4'd1;
    assign j_dec     = j_reg - 6'd1;
    assign diff_emit = {1'b0, r_dec, 2'b00} - {1'b0, j_reg};
    assign diff_step = {1'b0, r_reg, 2'b00} - {1'b0, j_dec};
    assign ge_emit   = (diff_emit[6:3] == 4'd0);
    assign ge_step   = (diff_step[6:3] == 4'd0);

    function automatic logic [127:0] pick(input word_t [7:0] w, input logic [2:0] off);
        return {w[off], w[off + 3'd1], w[off + 3'd2], w[off + 3'd3]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            win_reg      <= '0;
            j_reg        <= '0;
            r_reg        <= '0;
            phase_reg    <= '0;
            quot_reg     <= '0;
            kl_reg       <= '0;
            busy_reg     <= 1'b0;
            rk_valid_reg <= 1'b0;
            rk_out_reg   <= '0;
            rk_round_reg <= '0;
            done_reg     <= 1'b0;
`ifdef AES_INV_KS_ERR_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef AES_INV_KS_ERR_EN
            err_reg  <= (state_reg != IDLE) && bus.start;
`endif
            case (state_reg)
                IDLE: begin
                    // The loaded window always contains round Nr, so go straight to EMIT
                    if (bus.start && key_ok) begin
                        win_reg      <= kin_w;
                        kl_reg       <= bus.key_len;
                        j_reg        <= j0_of(bus.key_len);
                        r_reg        <= nr_of(bus.key_len);
                        phase_reg    <= 3'd3;
                        quot_reg     <= q0_of(bus.key_len);
                        busy_reg     <= 1'b1;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= pick(kin_w, 3'(nk_of(bus.key_len) - 4'd4));
                        rk_round_reg <= ROUND_W'(nr_of(bus.key_len));
                        state_reg    <= EMIT;
                    end
`ifdef AES_INV_KS_ERR_EN
                    else if (bus.start) begin
                        err_reg <= 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (bus.rk_ready) begin
                        if (r_reg == 4'd0) begin
                            busy_reg     <= 1'b0;
                            rk_valid_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            r_reg <= r_dec;
                            if (ge_emit) begin
                                rk_out_reg   <= pick(win_reg, diff_emit[2:0]);
                                rk_round_reg <= ROUND_W'(r_dec);
                            end else begin
                                rk_valid_reg <= 1'b0;
                                state_reg    <= STEP;
                            end
                        end
                    end
                end
                STEP: begin
                    win_reg <= win_shift;
                    j_reg   <= j_dec;
                    if (phase_reg == 3'd0) begin
                        phase_reg <= 3'(nk_of(kl_reg) - 4'd1);
                        quot_reg  <= quot_reg - 4'd1;
                    end else begin
                        phase_reg <= phase_reg - 3'd1;
                    end
                    if (ge_step) begin
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= pick(win_shift, diff_step[2:0]);
                        rk_round_reg <= ROUND_W'(r_reg);
                        state_reg    <= EMIT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.rk_valid = rk_valid_reg;
    assign bus.rk_out   = rk_out_reg;
    assign bus.rk_round = rk_round_reg;
    assign bus.done     = done_reg;
`ifdef AES_INV_KS_ERR_EN
    assign bus.err      = err_reg;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched: FIPS-197 keys, backpressure, reset abort, ignored starts.
// Forward expansion model supplies the load words and every expected round key.
module tb_aes_inv_key_sched;
    localparam int MAXB = 256;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] LAST128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] LAST192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] LAST256 = 128'hfe4890d1e6188d0b046df344706c631e;

    localparam logic [127:0] SBOX_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [31:0] ref_w [60];

    aes_inv_key_sched_if #(.MAX_KEY_BITS(MAXB), .ROUND_W(4)) bus ();

    aes_inv_key_sched #(.MAX_KEY_BITS(MAXB), .ROUND_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sbox_b(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROW[x[7:4]];
        return row[127 - 8 * int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] x);
        return {sbox_b(x[31:24]), sbox_b(x[23:16]), sbox_b(x[15:8]), sbox_b(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] rk_exp(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // Plain forward key expansion (FIPS-197 5.2)
    task automatic expand_key(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key_len = 2'b00;
        bus.kin = '0;
        bus.rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 128'h0 ||
            bus.rk_round !== 4'h0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b valid=%b out=%h round=%0d done=%b, expected all zero",
                     bus.busy, bus.rk_valid, bus.rk_out, bus.rk_round, bus.done);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One complete load-and-drain; bp randomises rk_ready, inject_at pulses start while busy
    task automatic test_sequence(input logic [1:0] kl, input bit bp, input int inject_at, input string tag);
        int nk, nr, exp_r, cycles, gap, maxgap;
        bit stalled, done_early, rdy;
        logic [255:0] key;
        logic [127:0] exp_last, first_out, last_out, held_out;
        logic [3:0] held_round;
        case (kl)
            2'b01:   begin nk = 6; key = KEY192; exp_last = LAST192; end
            2'b10:   begin nk = 8; key = KEY256; exp_last = LAST256; end
            default: begin nk = 4; key = KEY128; exp_last = LAST128; end
        endcase
        nr = nk + 6;
        expand_key(nk, key);
        bus.kin = '0;
        for (int k = 0; k < nk; k++) bus.kin[255-32*k -: 32] = ref_w[4*(nr+1)-nk+k];
        bus.key_len = kl;
        bus.rk_ready = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_vec++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s first_valid: valid=%b busy=%b, expected 1 1", tag, bus.rk_valid, bus.busy);
        end
        exp_r = nr; cycles = 0; gap = 0; maxgap = 0;
        stalled = 0; done_early = 0;
        first_out = '0; last_out = '0; held_out = '0; held_round = '0;
        while (exp_r >= 0 && cycles < 2000) begin
            if (stalled) begin
                n_vec++;
                if (bus.rk_valid !== 1'b1 || bus.rk_out !== held_out || bus.rk_round !== held_round) begin
                    n_err++;
                    $display("FAIL %s stall_hold: valid=%b round=%0d out=%h, expected 1 %0d %h",
                             tag, bus.rk_valid, bus.rk_round, bus.rk_out, held_round, held_out);
                end
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rk_ready = rdy;
            if (cycles == inject_at) begin
                bus.start = 1'b1;
                bus.key_len = (cycles % 2 == 0) ? 2'b11 : 2'b01;
            end
            stalled = 0;
            if (bus.rk_valid === 1'b1) begin
                if (gap > maxgap) maxgap = gap;
                gap = 0;
                if (rdy) begin
                    n_vec++;
                    if (bus.rk_round !== exp_r[3:0] || bus.rk_out !== rk_exp(exp_r)) begin
                        n_err++;
                        $display("FAIL %s round_key: round=%0d out=%h, expected round %0d out=%h",
                                 tag, bus.rk_round, bus.rk_out, exp_r, rk_exp(exp_r));
                    end
                    if (exp_r == nr) first_out = bus.rk_out;
                    if (exp_r == 0) last_out = bus.rk_out;
                    exp_r--;
                end else begin
                    stalled = 1;
                    held_out = bus.rk_out;
                    held_round = bus.rk_round;
                end
            end else begin
                gap++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (bus.start === 1'b1) begin
                bus.start = 1'b0;
                bus.key_len = kl;
`ifdef AES_INV_KS_ERR_EN
                n_vec++;
                if (bus.err !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s err_busy_start: err=%b, expected 1", tag, bus.err);
                end
`endif
            end
            if (exp_r >= 0 && bus.done !== 1'b0) done_early = 1;
        end
        n_vec++;
        if (exp_r >= 0) begin
            n_err++;
            $display("FAIL %s timeout: %0d rounds left after %0d cycles, expected 0", tag, exp_r + 1, cycles);
        end
        n_vec++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || done_early) begin
            n_err++;
            $display("FAIL %s done_pulse: done=%b busy=%b valid=%b early=%0d, expected 1 0 0 0",
                     tag, bus.done, bus.busy, bus.rk_valid, done_early);
        end
        n_vec++;
        if (first_out !== exp_last || last_out !== key[255 -: 128]) begin
            n_err++;
            $display("FAIL %s golden_ends: first=%h last=%h, expected %h %h",
                     tag, first_out, last_out, exp_last, key[255 -: 128]);
        end
        n_vec++;
        if (maxgap > 4) begin
            n_err++;
            $display("FAIL %s step_gap: max gap %0d, expected <= 4", tag, maxgap);
        end
        if (!bp) begin
            n_vec++;
            if (cycles != (nr + 1) + 4 * (nr + 1) - nk) begin
                n_err++;
                $display("FAIL %s total_cycles: %0d, expected %0d", tag, cycles, (nr + 1) + 4 * (nr + 1) - nk);
            end
        end
        bus.rk_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_width: done=%b one cycle later, expected 0", tag, bus.done);
        end
    endtask

    task automatic test_backpressure;
        test_sequence(2'b00, 1'b1, -1, "bp_aes128");
        test_sequence(2'b01, 1'b1, -1, "bp_aes192");
        test_sequence(2'b10, 1'b1, -1, "bp_aes256");
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit done_seen;
        expand_key(8, KEY256);
        bus.kin = '0;
        for (int k = 0; k < 8; k++) bus.kin[255-32*k -: 32] = ref_w[52+k];
        bus.key_len = 2'b10;
        bus.rk_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.rk_valid === 1'b1 && bus.rk_round === 4'd7) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++;
        if (cyc >= 200) begin
            n_err++;
            $display("FAIL reset_mid_reach: round 7 not seen in %0d cycles, expected within 200", cyc);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 128'h0 ||
            bus.rk_round !== 4'h0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_clear: busy=%b valid=%b out=%h round=%0d done=%b, expected all zero",
                     bus.busy, bus.rk_valid, bus.rk_out, bus.rk_round, bus.done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1;
        end
        n_vec++;
        if (done_seen) begin
            n_err++;
            $display("FAIL reset_mid_nodone: done/busy activity after abort=%0d, expected 0", done_seen);
        end
        test_sequence(2'b10, 1'b0, -1, "after_reset_aes256");
    endtask

    task automatic test_ignored_starts;
        bus.key_len = 2'b11;
        bus.kin = KEY256;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reserved_keylen: busy=%b valid=%b, expected 0 0", bus.busy, bus.rk_valid);
        end
`ifdef AES_INV_KS_ERR_EN
        n_vec++;
        if (bus.err !== 1'b1) begin
            n_err++;
            $display("FAIL err_reserved: err=%b, expected 1", bus.err);
        end
`endif
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reserved_idle: busy=%b, expected 0", bus.busy);
        end
        test_sequence(2'b00, 1'b0, 5, "busy_start_aes128");
        test_sequence(2'b01, 1'b0, 6, "busy_rsvd_aes192");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_sequence(2'b00, 1'b0, -1, "aes128");
        test_sequence(2'b01, 1'b0, -1, "aes192");
        test_sequence(2'b10, 1'b0, -1, "aes256");
        test_backpressure;
        test_reset_mid;
        test_ignored_starts;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
